// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} arb_state_t;
    typedef logic [7:0] byte_t;
    localparam int DEFAULT_TIMEOUT = 65535;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search for the first set request after last_i, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    always_comb begin
        logic [IDX_W-1:0] c;
        idx_o = last_i;
        c = last_i;
        // Walk from farthest to nearest so the closest request after last_i wins.
        for (int i = N; i >= 1; i--) begin
            c = IDX_W'((int'(last_i) + i) % N);
            if (req_i[c]) idx_o = c;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one UART TX among N requesters.
// Define UART_ARB_TIMEOUT_EN to drop an owner stalled for TIMEOUT cycles (adds o_timeout).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
`ifdef UART_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic [8*N-1:0]   i_data,
    input  logic [N-1:0]     i_last,
    output logic [N-1:0]     o_ack,
    output logic             o_tx_valid,
    output byte_t            o_tx_data,
    input  logic             i_tx_ready,
    input  logic             i_tx_idle,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_grant
`ifdef UART_ARB_TIMEOUT_EN
    , output logic           o_timeout
`endif
);
    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d, pick;
    logic             any_req, send, xfer, stall_out;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req_i (i_req),
        .last_i(grant_q),
        .idx_o (pick),
        .any_o (any_req)
    );

    assign send       = state_q == SEND;
    assign o_tx_valid = send & i_req[grant_q];
    assign o_tx_data  = send ? i_data[{grant_q, 3'b000} +: 8] : '0;
    assign xfer       = o_tx_valid & i_tx_ready;
    assign o_ack      = xfer ? N'(1) << grant_q : '0;
    assign o_busy     = state_q != IDLE;
    assign o_grant    = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    // Fires on the TIMEOUT-th consecutive cycle the owner has nothing to send.
    assign o_timeout = send & ~i_req[grant_q] & (stall_q == 16'(TIMEOUT - 1));
    assign stall_d   = (!send || xfer) ? '0 : stall_q + 16'(~i_req[grant_q]);
    assign stall_out = o_timeout;
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`else
    assign stall_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = SEND;
                grant_d = pick;
            end
            SEND: if ((xfer & i_last[grant_q]) | stall_out) state_d = DRAIN;
            default: if (i_tx_idle) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for the round-robin UART TX arbiter.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_req = '0;
    logic [N-1:0]   i_last = '0;
    logic [8*N-1:0] i_data = '0;
    logic           i_tx_ready = 1'b0;
    logic           i_tx_idle = 1'b0;
    logic [N-1:0]   o_ack;
    logic           o_tx_valid;
    logic [7:0]     o_tx_data;
    logic           o_busy;
    logic [IW-1:0]  o_grant;

    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [N][$];
    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ack     (o_ack),
        .o_tx_valid(o_tx_valid),
        .o_tx_data (o_tx_data),
        .i_tx_ready(i_tx_ready),
        .i_tx_idle (i_tx_idle),
        .o_busy    (o_busy),
        .o_grant   (o_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [IW-1:0] winner(input logic [N-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] c;
        for (int d = 1; d <= N; d++) begin
            c = IW'((int'(last) + d) % N);
            if (r[c]) return c;
        end
        return last;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += src_q[IW'(k)].size();
        return s;
    endfunction

    task automatic push(input int k, input logic [7:0] b, input logic l);
        src_q[IW'(k)].push_back({l, b});
        exp_q[IW'(k)].push_back({l, b});
    endtask

    task automatic add_msg(input int k, input int len);
        for (int j = 0; j < len; j++) push(k, 8'($urandom), j == len - 1);
    endtask

    task automatic drive(input int p_req, input int p_rdy);
        logic [IW-1:0]  kk;
        logic [N-1:0]   rq, ls;
        logic [8*N-1:0] dt;
        rq = '0;
        ls = '0;
        dt = '0;
        for (int k = 0; k < N; k++) begin
            kk = IW'(k);
            if (src_q[kk].size() > 0) begin
                rq[kk] = $urandom_range(99) < p_req;
                ls[kk] = src_q[kk][0][8];
                dt[{kk, 3'b000} +: 8] = src_q[kk][0][7:0];
            end else ls[kk] = 1'($urandom_range(1));
        end
        i_req = rq;
        i_last = ls;
        i_data = dt;
        i_tx_ready = $urandom_range(99) < p_rdy;
        i_tx_idle = 1'($urandom_range(1));
    endtask

    task automatic step(input int p_req, input int p_rdy);
        logic [N-1:0] a;
        drive(p_req, p_rdy);
        @(negedge clk);
        a = o_ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (a[IW'(k)]) void'(src_q[IW'(k)].pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '1;
        i_tx_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_q[IW'(k)].delete();
            exp_q[IW'(k)].delete();
        end
        @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_grant", int'(o_grant), N - 1);
        chk("rst_valid", int'(o_tx_valid), 0);
        chk("rst_ack", int'(o_ack), 0);
        chk("rst_data", int'(o_tx_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input int p_req, input int p_rdy);
        for (int n = 0; n < 3000; n++) begin
            if (pending() == 0 && !o_busy) break;
            step(p_req, p_rdy);
        end
        chk("drained", pending() + int'(o_busy), 0);
    endtask

    // Monitor: message-level model of who owns the transmitter and what it must emit.
    initial begin
        logic          have_own, draining;
        logic [IW-1:0] own, last_own;
        have_own = 1'b0;
        draining = 1'b0;
        own = '0;
        last_own = IW'(N - 1);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_own = 1'b0;
                draining = 1'b0;
                last_own = IW'(N - 1);
            end else if (draining) begin
                chk("drain_valid", int'(o_tx_valid), 0);
                chk("drain_ack", int'(o_ack), 0);
                chk("drain_busy", int'(o_busy), 1);
                if (i_tx_idle) draining = 1'b0;
            end else if (!have_own) begin
                chk("idle_busy", int'(o_busy), 0);
                chk("idle_valid", int'(o_tx_valid), 0);
                chk("idle_ack", int'(o_ack), 0);
                chk("idle_grant", int'(o_grant), int'(last_own));
                if (|i_req) begin
                    own = winner(i_req, last_own);
                    last_own = own;
                    have_own = 1'b1;
                end
            end else begin
                chk("send_busy", int'(o_busy), 1);
                chk("send_grant", int'(o_grant), int'(own));
                chk("send_valid", int'(o_tx_valid), int'(i_req[own]));
                chk("send_ack", int'(o_ack), (i_req[own] && i_tx_ready) ? (1 << own) : 0);
                if (i_req[own]) begin
                    if (exp_q[own].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_extra: got byte %0h required none", o_tx_data);
                    end else begin
                        chk("tx_data", int'(o_tx_data), int'(exp_q[own][0][7:0]));
                        if (i_tx_ready) begin
                            if (exp_q[own][0][8]) begin
                                have_own = 1'b0;
                                draining = 1'b1;
                            end
                            void'(exp_q[own].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        add_msg(1, 2);
        add_msg(2, 1);
        add_msg(3, 3);
        wait_empty(100, 100);
        push(1, 8'h48, 1'b0);
        push(1, 8'h49, 1'b1);
        push(3, 8'h4F, 1'b0);
        push(3, 8'h4B, 1'b1);
        wait_empty(100, 100);
        add_msg(2, 5);
        for (int n = 0; n < 3; n++) step(100, 100);
        for (int n = 0; n < 100; n++) step(100, 0);
        wait_empty(100, 100);
        push(0, 8'h5A, 1'b1);
        for (int n = 0; n < 6; n++) step(100, 0);
        wait_empty(100, 100);
        add_msg(1, 5);
        for (int n = 0; n < 50 && src_q[1].size() > 3; n++) step(100, 100);
        chk("two_bytes_sent", src_q[1].size(), 3);
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(7) == 0 && pending() < 12)
                add_msg(int'($urandom_range(N - 1)), int'($urandom_range(1, 4)));
            step(int'($urandom_range(50, 100)), int'($urandom_range(30, 100)));
        end
        wait_empty(80, 80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
